// File: rtl/multi_listen.sv
// multi_listen: N-channel detector listener that turns raw lines into one-cycle
// event pulses, with a run-time dead time per channel and saturating singles counters.
//
// state     | meaning
// LISTENING | dc == 0, a trigger on this cycle's sample is accepted
// DEAD      | dc != 0, input ignored, dc counts down toward 0
module multi_listen #(
   parameter int N_CH   = 4,
   parameter int DEAD_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       raw_signal,
   input  logic [DEAD_W-1:0]     dead_time,
   input  logic                  edge_mode,
   input  logic                  enable,
   input  logic                  clear_counts,
   output logic [N_CH-1:0]       out_pulse,
   output logic [N_CH*CNT_W-1:0] hit_count
);

   logic [DEAD_W-1:0] dc  [N_CH];
   logic [CNT_W-1:0]  cnt [N_CH];
   logic [N_CH-1:0]   prev;
   logic [N_CH-1:0]   listening;
   logic [N_CH-1:0]   trig;

   always_comb begin
      listening = '0;
      trig      = '0;
      for (int i = 0; i < N_CH; i++) begin
         listening[i] = (dc[i] == '0);
         trig[i]      = listening[i] & enable & raw_signal[i] & (edge_mode ? ~prev[i] : 1'b1);
      end
   end

   // prev resets high so a line already asserted at reset release is not seen as a rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         out_pulse <= '0;
         prev      <= '1;
         for (int i = 0; i < N_CH; i++) begin
            dc[i]  <= '0;
            cnt[i] <= '0;
         end
      end else begin
         prev <= raw_signal;
         for (int i = 0; i < N_CH; i++) begin
            out_pulse[i] <= trig[i];
            if (!listening[i]) begin
               dc[i] <= dc[i] - DEAD_W'(1);
            end else if (trig[i]) begin
               dc[i] <= dead_time;
            end
            if (clear_counts) begin
               cnt[i] <= trig[i] ? CNT_W'(1) : '0;
            end else if (trig[i] && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign hit_count[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: doc/multi_listen.md
# multi_listen

Multi-channel detector front end that turns raw detector lines into clean single-cycle event pulses with per-channel dead time, ahead of the coincidence logic. It generalises the single-channel fixed-dead-time listener to `N_CH` channels, a run-time dead time, a selectable level/rising-edge trigger mode, a global enable, and saturating per-channel accepted-event counters for singles rates.

## Interface
- `N_CH`, 4: number of independent input channels.
- `DEAD_W`, 8: width of the dead-time setting and of each channel's dead counter.
- `CNT_W`, 32: width of each per-channel hit counter.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raw_signal`  in  N_CH  raw detector lines, bit i = channel i; synchronous to `clk` (any synchronisers sit upstream).
- `dead_time`  in  DEAD_W  dead-time length D in cycles, sampled per channel at trigger.
- `edge_mode`  in  1  0 = level trigger, 1 = rising-edge trigger.
- `enable`  in  1  1 = accept new triggers; 0 = accept none.
- `clear_counts`  in  1  synchronous clear of all hit counters.
- `out_pulse`  out  N_CH  one-cycle event pulse per channel.
- `hit_count`  out  N_CH*CNT_W  accepted-event count; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Channels are fully independent. The only shared inputs are `dead_time`, `edge_mode`, `enable` and `clear_counts`.
- Per-channel state:
  - dead counter `dc[i]` (DEAD_W bits);
  - previous-sample register `prev[i]`;
  - pulse register;
  - hit counter.
- Channel i is LISTENING when `dc[i]==0` and DEAD when `dc[i]!=0`.
- Trigger condition (LISTENING only): `enable & raw_signal[i] & (edge_mode ? ~prev[i] : 1)`.
- On a trigger edge:
  - `out_pulse[i]<=1`;
  - `dc[i]<=dead_time` (value captured at that edge);
  - `hit_count[i]` increments.
- In DEAD state:
  - `out_pulse[i]<=0`;
  - `dc[i]<=dc[i]-1`;
  - input is ignored and not counted.
- Otherwise `out_pulse[i]<=0` and `dc[i]` holds.
- `prev[i]<=raw_signal[i]` every cycle, regardless of state, `enable` or mode. Edge detection therefore sees true line history. A line that rises during DEAD and stays high does not trigger in edge mode once LISTENING resumes.
- `enable` low blocks new triggers only. Running dead countdowns continue, and a pulse already registered completes.
- `dead_time` changes affect only subsequent triggers.
- `D==0`: no dead time. In level mode a held-high line pulses every cycle. In edge mode it pulses once per rising edge.
- Hit counters:
  - saturate at 2^CNT_W-1 (no wrap);
  - `clear_counts` zeroes all counters;
  - clear and trigger on the same edge leaves that channel's count at 1.
- Reset values:
  - `out_pulse`=0;
  - all `dc`=0 (LISTENING);
  - all `hit_count`=0;
  - all `prev`=1, so a line already high at reset release does not register as a rising edge.
- `rst` mid-dead-time aborts the countdown. The channel is LISTENING on the first cycle after `rst` deasserts.

## Timing
- Latency: input sampled high at edge t produces `out_pulse` high during cycle t..t+1, exactly one cycle wide. `hit_count` updates at the same edge.
- Dead window: edges t+1..t+D are DEAD. The earliest next accepted sample is at edge t+D+1, so the minimum pulse spacing is D+1 cycles.
- Edge mode adds no latency. `prev` holds the sample from edge t-1.
- Throughput: one event per channel per D+1 cycles. Simultaneous triggers on all channels are all accepted in the same cycle.

## Test plan
- Level mode, D=5, ch0 held high for 20 cycles: pulses at edges 0, 6, 12, 18 (4 pulses, spacing 6). `hit_count[0]`=4. Other channels stay at 0.
- Edge mode, D=3, ch1 high for 10 cycles, low 2, high 1: exactly 2 pulses (first rise, second rise). A rise occurring during DEAD is not counted.
- D=0, level mode, ch2 high 8 cycles: 8 consecutive pulse cycles, count 8. Repeating in edge mode gives 1 pulse.
- `enable`=0 during a trigger, then `enable`=1 while the line is still high: level mode fires on the first enabled cycle; edge mode does not fire. A countdown begun before `enable` dropped still expires on schedule.
- Preload a counter near saturation (CNT_W=4 build) and drive 20 hits: count stops at 15. Assert `clear_counts` on the same edge as a trigger: count reads 1.
- Assert `rst` 2 cycles into a D=10 dead window with the line high: `out_pulse`=0 and count=0 after reset. Level mode pulses on the first post-reset edge; edge mode does not pulse (`prev` reset to 1).
